switch_allocator: RTL

- Per-cycle switch allocator (CBA) for the 5x5 router crossbar.
- Arbitrates input-buffer head flits for the five output ports and drives the crossbar 3-bit output selects.
- Locks each output to one input from head flit to tail flit (wormhole), with round-robin fairness per output.
- Port index: 0 north, 1 east, 2 south, 3 west, 4 local. Select codes use the same index; SEL_IDLE drives zero data and valid through the crossbar.

---
 rtl/switch_allocator.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : switch_allocator
// Description : 5x5 crossbar switch allocator with per-output round-robin
//               arbitration and wormhole (head-to-tail) output locking.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_allocator #(
    parameter logic [2:0] SEL_IDLE = 3'b111,
    parameter logic       LOCK_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  req_valid,
    input  logic [14:0] req_port,
    input  logic [4:0]  req_head,
    input  logic [4:0]  req_tail,
    input  logic [4:0]  out_ready,
    output logic [4:0]  grant,
    output logic [2:0]  north_out_select,
    output logic [2:0]  east_out_select,
    output logic [2:0]  south_out_select,
    output logic [2:0]  west_out_select,
    output logic [2:0]  local_out_select,
    output logic [4:0]  out_locked,
    output logic [4:0]  req_err
);

    localparam int c_N = 5;

    logic [4:0] r_locked;
    logic [2:0] r_owner [c_N];
    logic [2:0] r_rr    [c_N];

    logic [2:0] w_port   [c_N];
    logic [4:0] w_err;
    logic [4:0] w_cand   [c_N];
    logic [4:0] w_found;
    logic [2:0] w_winner [c_N];
    logic [2:0] w_next   [c_N];
    logic [4:0] w_xfer;
    logic [2:0] w_sel    [c_N];
    logic [4:0] w_grant;
    logic [3:0] w_sum;
    logic [2:0] w_idx;

    generate
        for (genvar gi = 0; gi < c_N; gi++) begin : g_port
            assign w_port[gi] = req_port[3*gi +: 3];
        end
    endgenerate

    // Out-of-range ports and U-turns are flagged; local->local loopback is legal.
    always_comb begin
        w_err = '0;
        for (int i = 0; i < c_N; i++) begin
            if (req_valid[i] && ((w_port[i] > 3'd4) || ((i < 4) && (w_port[i] == 3'(i)))))
                w_err[i] = 1'b1;
        end
    end

    always_comb begin
        for (int o = 0; o < c_N; o++) begin
            w_cand[o] = '0;
            for (int i = 0; i < c_N; i++) begin
                if (req_valid[i] && !w_err[i] && (w_port[i] == 3'(o))) begin
                    if (!LOCK_EN)
                        w_cand[o][i] = 1'b1;
                    else if (r_locked[o])
                        w_cand[o][i] = (r_owner[o] == 3'(i)) && !req_head[i];
                    else
                        w_cand[o][i] = req_head[i];
                end
            end
        end
    end

    // Round-robin scan starting at the output's pointer, wrapping modulo 5.
    always_comb begin
        w_sum = '0;
        w_idx = '0;
        for (int o = 0; o < c_N; o++) begin
            w_found[o]  = 1'b0;
            w_winner[o] = 3'd0;
            for (int k = 0; k < c_N; k++) begin
                w_sum = {1'b0, r_rr[o]} + 4'(k);
                w_idx = (w_sum >= 4'd5) ? 3'(w_sum - 4'd5) : w_sum[2:0];
                if (!w_found[o] && w_cand[o][w_idx]) begin
                    w_found[o]  = 1'b1;
                    w_winner[o] = w_idx;
                end
            end
            w_next[o] = (w_winner[o] == 3'd4) ? 3'd0 : w_winner[o] + 3'd1;
        end
    end

    always_comb begin
        w_grant = '0;
        for (int o = 0; o < c_N; o++) begin
            w_xfer[o] = !rst && w_found[o] && out_ready[o];
            w_sel[o]  = w_xfer[o] ? w_winner[o] : SEL_IDLE;
        end
        for (int i = 0; i < c_N; i++) begin
            for (int o = 0; o < c_N; o++) begin
                if (w_xfer[o] && (w_winner[o] == 3'(i)))
                    w_grant[i] = 1'b1;
            end
        end
    end

    assign grant            = w_grant;
    assign north_out_select = w_sel[0];
    assign east_out_select  = w_sel[1];
    assign south_out_select = w_sel[2];
    assign west_out_select  = w_sel[3];
    assign local_out_select = w_sel[4];
    assign req_err          = rst ? 5'd0 : w_err;
    assign out_locked       = rst ? 5'd0 : r_locked;

    // Pointer moves past the winner only when a packet completes, so a
    // locked packet keeps its fairness position until the tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_locked <= '0;
            for (int o = 0; o < c_N; o++) begin
                r_owner[o] <= 3'd0;
                r_rr[o]    <= 3'd0;
            end
        end else begin
            for (int o = 0; o < c_N; o++) begin
                if (w_xfer[o]) begin
                    if (LOCK_EN) begin
                        if (req_tail[w_winner[o]]) begin
                            r_locked[o] <= 1'b0;
                            r_rr[o]     <= w_next[o];
                        end else begin
                            r_locked[o] <= 1'b1;
                            r_owner[o]  <= w_winner[o];
                        end
                    end else begin
                        r_rr[o] <= w_next[o];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
